// File: rtl/ram_accum_pkg.sv
// Shared types and sizing for the scatter-accumulate controller and its output FIFO.
// DEPTH/WIDTH must track the attached ram_2r1w instance.
package ram_accum_pkg;

    localparam int DEPTH    = 32;
    localparam int WIDTH    = 32;
    localparam int ADDR_LEN = $clog2(DEPTH);

    typedef enum logic {
        ACCUM = 1'b0,
        DRAIN = 1'b1
    } state_e;

    typedef struct packed {
        logic [ADDR_LEN-1:0] addr;
        logic [WIDTH-1:0]    data;
    } drain_ent_t;

endpackage

// File: rtl/ram_accum_ofifo.sv
// 2-entry valid/ready FIFO of drained entries; registered head, pop visible next cycle.
// No push-side ready: the producer only issues reads when a slot is guaranteed free.
module ram_accum_ofifo
    import ram_accum_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       push_vld_i,
    input  drain_ent_t push_dat_i,
    output logic       pop_vld_o,
    output drain_ent_t pop_dat_o,
    input  logic       pop_rdy_i,
    output logic [1:0] count_o
);

    drain_ent_t mem_q [2];
    logic       wr_ptr_q;
    logic       rd_ptr_q;
    logic [1:0] cnt_q;
    logic [1:0] cnt_d;
    logic       pop;

    assign pop_vld_o = (cnt_q != 2'd0);
    assign pop_dat_o = mem_q[rd_ptr_q];
    assign count_o   = cnt_q;
    assign pop       = pop_vld_o && pop_rdy_i;
    assign cnt_d     = cnt_q + {1'b0, push_vld_i} - {1'b0, pop};

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            mem_q[0] <= '0;
            mem_q[1] <= '0;
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            cnt_q    <= 2'd0;
        end else begin
            if (push_vld_i) begin
                mem_q[wr_ptr_q] <= push_dat_i;
                wr_ptr_q        <= ~wr_ptr_q;
            end
            if (pop) begin
                rd_ptr_q <= ~rd_ptr_q;
            end
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/ram_accum_ctrl.sv
// Scatter-accumulate controller for ram_2r1w: 1 update/cycle read-add-write, then drain-and-clear.
// Update write lands 1 cycle after accept; drain output stalls on out_ready with a 2-deep buffer.
module ram_accum_ctrl
    import ram_accum_pkg::*;
(
    input  logic                clk,
    input  logic                rst_n,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [ADDR_LEN-1:0] in_addr,
    input  logic [WIDTH-1:0]    in_data,
    input  logic                drain_start,
    output logic                busy,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [ADDR_LEN-1:0] out_addr,
    output logic [WIDTH-1:0]    out_data,
    output logic                drain_done,
    output logic                ram_rd_valid,
    output logic [ADDR_LEN-1:0] ram_rd_addr,
    input  logic [WIDTH-1:0]    ram_rd_data,
    input  logic                ram_rd_dvalid,
    output logic                ram_wr_valid,
    output logic [ADDR_LEN-1:0] ram_wr_addr,
    output logic [WIDTH-1:0]    ram_wr_data
);

    localparam int RP_W = ADDR_LEN + 1;

    state_e              state_q;
    logic                s1_vld_q;
    logic [ADDR_LEN-1:0] s1_addr_q;
    logic [WIDTH-1:0]    s1_data_q;
    logic                byp_vld_q;
    logic [WIDTH-1:0]    byp_data_q;
    logic [RP_W-1:0]     rp_q;
    logic                infl_q;
    logic [ADDR_LEN-1:0] infl_addr_q;

    logic                in_drain;
    logic                accept;
    logic                rd_issue;
    logic                pop;
    logic [WIDTH-1:0]    base;
    logic [WIDTH-1:0]    sum;
    logic [1:0]          fifo_cnt;
    logic [1:0]          occ;
    drain_ent_t          push_dat;
    drain_ent_t          head;

    assign in_drain = (state_q == DRAIN);
    assign in_ready = !in_drain && !drain_start;
    assign accept   = in_valid && in_ready;
    assign busy     = in_drain;

    // The RAM read for the previous accept misses a write issued in the same cycle; bypass covers that.
    assign base = byp_vld_q ? byp_data_q : ram_rd_data;
    assign sum  = base + s1_data_q;

    // Occupancy after this cycle's pop keeps the drain at one entry per cycle with out_ready high.
    assign pop      = out_valid && out_ready;
    assign occ      = fifo_cnt - {1'b0, pop};
    assign rd_issue = in_drain && (rp_q < RP_W'(DEPTH)) && ((occ + {1'b0, infl_q}) < 2'd2);

    assign ram_rd_valid = accept || rd_issue;
    assign ram_rd_addr  = accept ? in_addr : rp_q[ADDR_LEN-1:0];
    assign ram_wr_valid = s1_vld_q || rd_issue;
    assign ram_wr_addr  = s1_vld_q ? s1_addr_q : rp_q[ADDR_LEN-1:0];
    assign ram_wr_data  = s1_vld_q ? sum : '0;

    assign push_dat   = '{addr: infl_addr_q, data: ram_rd_data};
    assign out_addr   = head.addr;
    assign out_data   = head.data;
    assign drain_done = in_drain && pop && (out_addr == ADDR_LEN'(DEPTH - 1));

    ram_accum_ofifo u_ofifo (
        .clk        (clk),
        .rst_n      (rst_n),
        .push_vld_i (infl_q && ram_rd_dvalid),
        .push_dat_i (push_dat),
        .pop_vld_o  (out_valid),
        .pop_dat_o  (head),
        .pop_rdy_i  (out_ready),
        .count_o    (fifo_cnt)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= ACCUM;
            s1_vld_q    <= 1'b0;
            s1_addr_q   <= '0;
            s1_data_q   <= '0;
            byp_vld_q   <= 1'b0;
            byp_data_q  <= '0;
            rp_q        <= '0;
            infl_q      <= 1'b0;
            infl_addr_q <= '0;
        end else begin
            s1_vld_q  <= accept;
            byp_vld_q <= accept && s1_vld_q && (in_addr == s1_addr_q);
            if (accept) begin
                s1_addr_q <= in_addr;
                s1_data_q <= in_data;
            end
            if (accept && s1_vld_q && (in_addr == s1_addr_q)) begin
                byp_data_q <= sum;
            end
            infl_q <= rd_issue;
            if (rd_issue) begin
                infl_addr_q <= rp_q[ADDR_LEN-1:0];
            end
            case (state_q)
                ACCUM: begin
                    if (drain_start) begin
                        state_q <= DRAIN;
                        rp_q    <= '0;
                    end
                end
                DRAIN: begin
                    if (rd_issue) begin
                        rp_q <= rp_q + 1'b1;
                    end
                    if (drain_done) begin
                        state_q <= ACCUM;
                    end
                end
                default: state_q <= ACCUM;
            endcase
        end
    end

endmodule

// File: tb/tb_ram_accum_ctrl.sv
// Bench for ram_accum_ctrl against a behavioural ram_2r1w and a per-address running-sum model.
module tb_ram_accum_ctrl;
    import ram_accum_pkg::*;

    logic                clk;
    logic                rst_n;
    logic                in_valid;
    logic                in_ready;
    logic [ADDR_LEN-1:0] in_addr;
    logic [WIDTH-1:0]    in_data;
    logic                drain_start;
    logic                busy;
    logic                out_valid;
    logic                out_ready;
    logic [ADDR_LEN-1:0] out_addr;
    logic [WIDTH-1:0]    out_data;
    logic                drain_done;
    logic                ram_rd_valid;
    logic [ADDR_LEN-1:0] ram_rd_addr;
    logic [WIDTH-1:0]    ram_rd_data;
    logic                ram_rd_dvalid;
    logic                ram_wr_valid;
    logic [ADDR_LEN-1:0] ram_wr_addr;
    logic [WIDTH-1:0]    ram_wr_data;

    int total;
    int bad;
    logic [31:0] ref_mem [DEPTH];
    logic [31:0] got     [DEPTH];
    logic [31:0] ram_mem [DEPTH];

    ram_accum_ctrl dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .in_addr       (in_addr),
        .in_data       (in_data),
        .drain_start   (drain_start),
        .busy          (busy),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .out_addr      (out_addr),
        .out_data      (out_data),
        .drain_done    (drain_done),
        .ram_rd_valid  (ram_rd_valid),
        .ram_rd_addr   (ram_rd_addr),
        .ram_rd_data   (ram_rd_data),
        .ram_rd_dvalid (ram_rd_dvalid),
        .ram_wr_valid  (ram_wr_valid),
        .ram_wr_addr   (ram_wr_addr),
        .ram_wr_data   (ram_wr_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ram_2r1w behaviour: read in t returns in t+1 and sees writes from cycles <= t-1.
    always @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) ram_mem[i] <= '0;
            ram_rd_data   <= '0;
            ram_rd_dvalid <= 1'b0;
        end else begin
            ram_rd_dvalid <= ram_rd_valid;
            if (ram_rd_valid) ram_rd_data <= ram_mem[ram_rd_addr];
            if (ram_wr_valid) ram_mem[ram_wr_addr] <= ram_wr_data;
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic clear_ref();
        for (int i = 0; i < DEPTH; i++) ref_mem[i] = '0;
    endtask

    // All tasks start and end at posedge+1; outputs are sampled at posedge+4.
    task automatic do_reset();
        rst_n = 1'b0; in_valid = 1'b0; in_addr = '0; in_data = '0;
        drain_start = 1'b0; out_ready = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #3;
        chk("rst_busy", 32'(busy), 0);
        chk("rst_out_valid", 32'(out_valid), 0);
        chk("rst_drain_done", 32'(drain_done), 0);
        chk("rst_wr_valid", 32'(ram_wr_valid), 0);
        chk("rst_rd_valid", 32'(ram_rd_valid), 0);
        chk("rst_out_data", out_data, 0);
        chk("rst_out_addr", 32'(out_addr), 0);
        chk("rst_wr_data", ram_wr_data, 0);
        chk("rst_wr_addr", 32'(ram_wr_addr), 0);
        chk("rst_rd_addr", 32'(ram_rd_addr), 0);
        clear_ref();
        rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic upd(input logic [4:0] a, input logic [31:0] d);
        in_valid = 1'b1; in_addr = a; in_data = d; #3;
        chk("upd_in_ready", 32'(in_ready), 1);
        chk("upd_busy", 32'(busy), 0);
        chk("upd_rd_valid", 32'(ram_rd_valid), 1);
        chk("upd_rd_addr", 32'(ram_rd_addr), 32'(a));
        if (in_ready) ref_mem[a] = ref_mem[a] + d;
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk); #1;
        end
    endtask

    // mode 0: out_ready high, 1: ready pattern 1,0,0, 2: random ready plus stray drain_start.
    task automatic run_drain(input int mode);
        int idx, cyc, first_hs, last_hs;
        bit stalled;
        logic [4:0]  ha;
        logic [31:0] hd;
        idx = 0; cyc = 0; first_hs = -1; last_hs = -1; stalled = 1'b0; ha = '0; hd = '0;
        drain_start = 1'b1; in_valid = 1'b0; #3;
        chk("start_in_ready", 32'(in_ready), 0);
        chk("start_busy", 32'(busy), 0);
        @(posedge clk); #1;
        drain_start = 1'b0;
        while (idx < DEPTH && cyc < 400) begin
            case (mode)
                0: out_ready = 1'b1;
                1: out_ready = (cyc % 3 == 0);
                default: begin
                    out_ready   = 1'($urandom_range(0, 1));
                    drain_start = 1'($urandom_range(0, 1));
                end
            endcase
            #3;
            chk("drain_busy", 32'(busy), 1);
            if (stalled) begin
                chk("hold_valid", 32'(out_valid), 1);
                chk("hold_addr", 32'(out_addr), 32'(ha));
                chk("hold_data", out_data, hd);
            end
            if (out_valid && out_ready) begin
                chk("out_addr", 32'(out_addr), 32'(idx));
                chk("out_data", out_data, ref_mem[idx]);
                chk("drain_done", 32'(drain_done), 32'(idx == DEPTH - 1));
                got[idx] = out_data;
                ref_mem[idx] = '0;
                if (first_hs < 0) first_hs = cyc;
                last_hs = cyc;
                idx++;
                stalled = 1'b0;
            end else begin
                chk("done_idle", 32'(drain_done), 0);
                stalled = out_valid;
                ha = out_addr;
                hd = out_data;
            end
            @(posedge clk); #1;
            cyc++;
        end
        drain_start = 1'b0;
        out_ready   = 1'b0;
        if (idx < DEPTH) chk("drain_timeout", 32'(idx), 32'(DEPTH));
        if (mode == 0) chk("drain_throughput", 32'(last_hs - first_hs), 32'(DEPTH - 1));
        #3;
        chk("post_busy", 32'(busy), 0);
        chk("post_valid", 32'(out_valid), 0);
        @(posedge clk); #1;
    endtask

    typedef struct {
        int                n;
        int                gap;
        logic [3:0][4:0]   a;
        logic [3:0][31:0]  d;
        logic [4:0]        ea0;
        logic [31:0]       ev0;
        logic [4:0]        ea1;
        logic [31:0]       ev1;
    } vec_t;

    vec_t vt [5];

    initial begin
        total = 0;
        bad   = 0;
        // Element [0] is the rightmost in each concatenation.
        vt[0] = '{n: 3, gap: 2, a: {5'd0, 5'd3, 5'd7, 5'd3},
                  d: {32'd0, 32'd1, 32'd10, 32'd5}, ea0: 5'd3, ev0: 32'd6, ea1: 5'd7, ev1: 32'd10};
        vt[1] = '{n: 4, gap: 0, a: {5'd9, 5'd9, 5'd9, 5'd9},
                  d: {32'd1, 32'd1, 32'd1, 32'd1}, ea0: 5'd9, ev0: 32'd4, ea1: 5'd10, ev1: 32'd0};
        vt[2] = '{n: 3, gap: 0, a: {5'd0, 5'd4, 5'd5, 5'd4},
                  d: {32'd0, 32'd7, 32'd3, 32'd2}, ea0: 5'd4, ev0: 32'd9, ea1: 5'd5, ev1: 32'd3};
        vt[3] = '{n: 2, gap: 0, a: {5'd0, 5'd0, 5'd0, 5'd0},
                  d: {32'd0, 32'd0, 32'd2, 32'hFFFF_FFFF}, ea0: 5'd0, ev0: 32'd1, ea1: 5'd1, ev1: 32'd0};
        vt[4] = '{n: 2, gap: 1, a: {5'd0, 5'd0, 5'd0, 5'd0},
                  d: {32'd0, 32'd0, 32'd2, 32'hFFFF_FFFF}, ea0: 5'd0, ev0: 32'd1, ea1: 5'd31, ev1: 32'd0};

        do_reset();
        run_drain(0);
        for (int i = 0; i < DEPTH; i++) chk("empty_drain", got[i], 0);

        for (int v = 0; v < 5; v++) begin
            for (int k = 0; k < vt[v].n; k++) begin
                upd(vt[v].a[k], vt[v].d[k]);
                idle(vt[v].gap);
            end
            run_drain(0);
            chk("vec_val0", got[vt[v].ea0], vt[v].ev0);
            chk("vec_val1", got[vt[v].ea1], vt[v].ev1);
            if (v == 3) begin
                run_drain(1);
                for (int i = 0; i < DEPTH; i++) chk("second_drain", got[i], 0);
            end
        end

        for (int r = 0; r < 3; r++) begin
            for (int c = 0; c < 150; c++) begin
                in_valid = ($urandom_range(0, 3) != 0);
                in_addr  = (r == 0) ? 5'($urandom_range(0, 3)) : 5'($urandom_range(0, 31));
                in_data  = $urandom;
                #3;
                chk("rnd_in_ready", 32'(in_ready), 1);
                if (in_valid && in_ready) ref_mem[in_addr] = ref_mem[in_addr] + in_data;
                @(posedge clk); #1;
            end
            in_valid = 1'b0;
            run_drain((r == 1) ? 1 : 2);
        end

        // Reset in the middle of a drain with data pending.
        upd(5'd2, 32'd77);
        upd(5'd30, 32'd5);
        drain_start = 1'b1; #3;
        @(posedge clk); #1;
        drain_start = 1'b0;
        out_ready   = 1'b1;
        idle(5);
        rst_n = 1'b0;
        out_ready = 1'b0;
        @(posedge clk); #3;
        chk("midrst_busy", 32'(busy), 0);
        chk("midrst_out_valid", 32'(out_valid), 0);
        chk("midrst_wr_valid", 32'(ram_wr_valid), 0);
        chk("midrst_drain_done", 32'(drain_done), 0);
        rst_n = 1'b1;
        clear_ref();
        @(posedge clk); #1;
        run_drain(0);
        for (int i = 0; i < DEPTH; i++) chk("post_rst_drain", got[i], 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
